// File: rtl/pool_feature_serializer_pkg.sv
// ---------------------------------------------------------------------------
// pool_feature_serializer_pkg
// Shared layer-1 definitions used by the pooling stage and the serializer.
//   CHANNELS / FEATURE_BITWIDTH      : per-pixel channel count and value width
//   POOL_OUT_WIDTH / POOL_OUT_HEIGHT : geometry of the pooled feature map
//   serState_t                       : serializer FSM state encoding
//   pixelSliceBase()                 : LSB position of one channel value of
//                                      one pixel inside a packed frame vector
// ---------------------------------------------------------------------------
package pool_feature_serializer_pkg;

    localparam int CHANNELS         = 4;
    localparam int FEATURE_BITWIDTH = 8;
    localparam int POOL_OUT_WIDTH   = 14;
    localparam int POOL_OUT_HEIGHT  = 14;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } serState_t;

    // Frames are packed channel-major: all pixels of channel 0 first, then
    // channel 1, and so on; within a channel pixels are in raster order.
    // The pooling stage packs with this same function, so both ends agree.
    function automatic int pixelSliceBase(input int channel,
                                          input int pixelIdx,
                                          input int pixPerFrame,
                                          input int featureBits);
        return (channel * featureBits * pixPerFrame) + (pixelIdx * featureBits);
    endfunction

endpackage

// File: rtl/fmap_raster_counter.sv
// ---------------------------------------------------------------------------
// fmap_raster_counter
// Raster-order x/y position counter for a MAP_WIDTH x MAP_HEIGHT feature map.
//   clk, rst             : clock, synchronous active-high reset
//   i_clear              : force position back to (0,0) (wins over advance)
//   i_advance            : step to the next pixel in raster order, wrapping
//                          from the last pixel back to (0,0)
//   o_x, o_y             : current position
//   o_nextX, o_nextY     : position that i_advance would move to
//   o_eol                : current pixel is the last of its row
//   o_last               : current pixel is the last of the frame
// ---------------------------------------------------------------------------
module fmap_raster_counter #(
    parameter int MAP_WIDTH  = 14,
    parameter int MAP_HEIGHT = 14,
    parameter int X_W        = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1,
    parameter int Y_W        = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic [X_W-1:0] o_nextX,
    output logic [Y_W-1:0] o_nextY,
    output logic           o_eol,
    output logic           o_last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(MAP_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(MAP_HEIGHT - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_eol;
    logic           w_last;
    logic [X_W-1:0] w_nextX;
    logic [Y_W-1:0] w_nextY;

    assign w_eol  = (r_x == X_LAST);
    assign w_last = w_eol && (r_y == Y_LAST);

    // Work out where the next advance lands: x wraps at the end of a row and
    // carries into y, and y wraps at the bottom of the frame.
    always_comb begin
        w_nextX = w_eol ? '0 : r_x + 1'b1;
        w_nextY = r_y;
        if (w_eol) begin
            w_nextY = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end
    end

    // Position registers; clear has priority so a new frame can start on the
    // same edge that would otherwise advance the old one.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            r_x <= w_nextX;
            r_y <= w_nextY;
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_nextX = w_nextX;
    assign o_nextY = w_nextY;
    assign o_eol   = w_eol;
    assign o_last  = w_last;

endmodule

// File: rtl/pool_feature_serializer.sv
// ---------------------------------------------------------------------------
// pool_feature_serializer
// Captures one whole pooled frame and streams it out pixel by pixel in
// raster order, all channels of a pixel in parallel, over valid/ready.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : one-cycle frame pulse from the pooling stage
//   in_ready        : a frame offered this cycle would be captured
//   feature_map_in  : packed frame (layout given by pixelSliceBase)
//   out_valid       : out_* fields hold a beat
//   out_ready       : downstream takes the beat
//   out_data        : channels of one pixel, channel c at [c*FB +: FB]
//   out_x, out_y    : position of the current beat
//   out_sof/eol/eof : first pixel / end of row / last pixel of frame
//   frame_done      : one-cycle pulse after the final beat is taken
//   overrun_err     : sticky, a frame was offered while not ready
// ---------------------------------------------------------------------------
module pool_feature_serializer #(
    parameter int CHANNELS         = pool_feature_serializer_pkg::CHANNELS,
    parameter int FEATURE_BITWIDTH = pool_feature_serializer_pkg::FEATURE_BITWIDTH,
    parameter int MAP_WIDTH        = pool_feature_serializer_pkg::POOL_OUT_WIDTH,
    parameter int MAP_HEIGHT       = pool_feature_serializer_pkg::POOL_OUT_HEIGHT,
    parameter int PIX_CNT_W        = $clog2(MAP_WIDTH * MAP_HEIGHT)
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [CHANNELS*FEATURE_BITWIDTH*MAP_WIDTH*MAP_HEIGHT-1:0] feature_map_in,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [CHANNELS*FEATURE_BITWIDTH-1:0]                   out_data,
    output logic [$clog2(MAP_WIDTH)-1:0]                           out_x,
    output logic [$clog2(MAP_HEIGHT)-1:0]                          out_y,
    output logic                                                   out_sof,
    output logic                                                   out_eol,
    output logic                                                   out_eof,
    output logic                                                   frame_done,
    output logic                                                   overrun_err
);

    import pool_feature_serializer_pkg::*;

    localparam int X_W           = $clog2(MAP_WIDTH);
    localparam int Y_W           = $clog2(MAP_HEIGHT);
    localparam int PIX_PER_FRAME = MAP_WIDTH * MAP_HEIGHT;
    localparam int FRAME_W       = CHANNELS * FEATURE_BITWIDTH * PIX_PER_FRAME;
    localparam int BEAT_W        = CHANNELS * FEATURE_BITWIDTH;

    serState_t            r_state;
    serState_t            w_nextState;
    logic [FRAME_W-1:0]   r_frame;
    logic [BEAT_W-1:0]    r_outData;
    logic [BEAT_W-1:0]    w_nextBeat;
    logic [BEAT_W-1:0]    w_firstBeat;
    logic                 r_frameDone;
    logic                 r_overrun;
    logic [X_W-1:0]       w_x;
    logic [Y_W-1:0]       w_y;
    logic [X_W-1:0]       w_nextX;
    logic [Y_W-1:0]       w_nextY;
    logic                 w_eol;
    logic                 w_lastPix;
    logic                 w_handshake;
    logic                 w_capture;
    logic [PIX_CNT_W-1:0] w_nextIdx;

    assign w_handshake = out_valid && out_ready;
    assign w_capture   = in_valid && in_ready;

    fmap_raster_counter #(
        .MAP_WIDTH  (MAP_WIDTH),
        .MAP_HEIGHT (MAP_HEIGHT),
        .X_W        (X_W),
        .Y_W        (Y_W)
    ) u_rasterCounter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_capture),
        .i_advance (w_handshake),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_nextX   (w_nextX),
        .o_nextY   (w_nextY),
        .o_eol     (w_eol),
        .o_last    (w_lastPix)
    );

    assign w_nextIdx = PIX_CNT_W'(int'(w_nextY) * MAP_WIDTH + int'(w_nextX));

    // Two beat candidates: pixel (0,0) straight from the input frame, used on
    // the capture edge so the first beat appears one cycle after in_valid
    // without waiting for the capture buffer, and the next raster pixel
    // taken from the capture buffer for every later beat.
    always_comb begin
        w_nextBeat  = '0;
        w_firstBeat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_nextBeat[c*FEATURE_BITWIDTH +: FEATURE_BITWIDTH] =
                r_frame[pixelSliceBase(c, int'(w_nextIdx), PIX_PER_FRAME, FEATURE_BITWIDTH) +: FEATURE_BITWIDTH];
            w_firstBeat[c*FEATURE_BITWIDTH +: FEATURE_BITWIDTH] =
                feature_map_in[pixelSliceBase(c, 0, PIX_PER_FRAME, FEATURE_BITWIDTH) +: FEATURE_BITWIDTH];
        end
    end

    // Capture buffer; its contents only matter while streaming, so it has no
    // reset and simply loads whenever a frame is accepted.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_frame <= feature_map_in;
        end
    end

    // Registered beat data. It only changes on capture or on an accepted beat,
    // which keeps it stable through any stall. After the last beat it is left
    // alone because out_valid is about to drop anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outData <= '0;
        end else if (w_capture) begin
            r_outData <= w_firstBeat;
        end else if (w_handshake && !w_lastPix) begin
            r_outData <= w_nextBeat;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: leave STREAM only when the last beat goes out with no
    // new frame waiting; a frame arriving on that edge continues streaming.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                if (w_handshake && w_lastPix && !in_valid) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: while streaming, a new frame can only be taken in the
    // cycle the last beat is being accepted, giving back-to-back frames.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            STREAM: begin
                out_valid = 1'b1;
                in_ready  = w_lastPix && out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
    end

    // Completion pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameDone <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frameDone <= w_handshake && w_lastPix;
            if (in_valid && !in_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_data    = r_outData;
    assign out_x       = w_x;
    assign out_y       = w_y;
    assign out_sof     = out_valid && (w_x == '0) && (w_y == '0);
    assign out_eol     = out_valid && w_eol;
    assign out_eof     = out_valid && w_lastPix;
    assign frame_done  = r_frameDone;
    assign overrun_err = r_overrun;

endmodule

// File: tb/tb_pool_feature_serializer.sv
// ---------------------------------------------------------------------------
// tb_pool_feature_serializer
// Bench for pool_feature_serializer: a 14x14x4 instance checked against a
// beat-queue reference model plus directed sequences, and a 4x4x2 instance
// checked directly.
// ---------------------------------------------------------------------------
module tb_pool_feature_serializer;

    localparam int C       = 4;
    localparam int FB      = 8;
    localparam int W       = 14;
    localparam int H       = 14;
    localparam int NPIX    = W * H;
    localparam int FRAME_W = C * FB * NPIX;
    localparam int SC      = 2;
    localparam int SW      = 4;
    localparam int SH      = 4;
    localparam int SNPIX   = SW * SH;
    localparam int NUM_VEC = 8;

    typedef struct {
        logic [C*FB-1:0] data;
        int              x;
        int              y;
        logic            sof;
        logic            eol;
        logic            eof;
    } beat_t;

    typedef struct {
        int          beatIdx;
        logic [31:0] expData;
        int          expX;
        int          expY;
        logic        expSof;
        logic        expEol;
        logic        expEof;
    } vector_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] feature_map_in;
    logic               out_valid;
    logic               out_ready;
    logic [C*FB-1:0]    out_data;
    logic [3:0]         out_x;
    logic [3:0]         out_y;
    logic               out_sof;
    logic               out_eol;
    logic               out_eof;
    logic               frame_done;
    logic               overrun_err;

    logic                  sRst;
    logic                  sInValid;
    logic                  sInReady;
    logic [SC*FB*SNPIX-1:0] sFeature;
    logic                  sOutValid;
    logic                  sOutReady;
    logic [SC*FB-1:0]      sOutData;
    logic [1:0]            sOutX;
    logic [1:0]            sOutY;
    logic                  sOutSof;
    logic                  sOutEol;
    logic                  sOutEof;
    logic                  sFrameDone;
    logic                  sOverrun;

    int         compared   = 0;
    int         mismatched = 0;
    bit         monOn      = 1'b0;
    beat_t      expQ[$];
    bit         expOverrun   = 1'b0;
    bit         expFrameDone = 1'b0;
    logic [7:0] frameTb [C][H][W];
    logic [7:0] sFrame  [SC][SH][SW];
    vector_t    vectors [NUM_VEC];

    always #5 clk = ~clk;

    pool_feature_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .feature_map_in (feature_map_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_sof        (out_sof),
        .out_eol        (out_eol),
        .out_eof        (out_eof),
        .frame_done     (frame_done),
        .overrun_err    (overrun_err)
    );

    pool_feature_serializer #(
        .CHANNELS   (SC),
        .MAP_WIDTH  (SW),
        .MAP_HEIGHT (SH)
    ) dutSmall (
        .clk            (clk),
        .rst            (sRst),
        .in_valid       (sInValid),
        .in_ready       (sInReady),
        .feature_map_in (sFeature),
        .out_valid      (sOutValid),
        .out_ready      (sOutReady),
        .out_data       (sOutData),
        .out_x          (sOutX),
        .out_y          (sOutY),
        .out_sof        (sOutSof),
        .out_eol        (sOutEol),
        .out_eof        (sOutEof),
        .frame_done     (sFrameDone),
        .overrun_err    (sOverrun)
    );

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the handshake inputs for one cycle.
    task automatic applyStimulus(input bit valid, input bit ready);
        in_valid  = valid;
        out_ready = ready;
        tick();
    endtask

    // Pack the bench's pixel array into the frame vector layout.
    task automatic packFrame();
        logic [FRAME_W-1:0] v;
        v = '0;
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    v[c*FB*NPIX + (y*W + x)*FB +: FB] = frameTb[c][y][x];
        feature_map_in = v;
    endtask

    task automatic loadPattern();
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    frameTb[c][y][x] = 8'((c << 6) | ((y*W + x) & 'h3F));
        packFrame();
    endtask

    task automatic loadRandom();
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    frameTb[c][y][x] = 8'($urandom_range(0, 255));
        packFrame();
    endtask

    // Reference model: an accepted frame becomes 196 expected beats in
    // raster order, read out of the offered frame vector.
    task automatic pushFrame();
        beat_t b;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                for (int c = 0; c < C; c++)
                    b.data[c*FB +: FB] = feature_map_in[c*FB*NPIX + (y*W + x)*FB +: FB];
                b.x   = x;
                b.y   = y;
                b.sof = (x == 0) && (y == 0);
                b.eol = (x == W - 1);
                b.eof = (x == W - 1) && (y == H - 1);
                expQ.push_back(b);
            end
        end
    endtask

    // Scoreboard on the falling edge: compare what the DUT shows against the
    // model, then update the model for what the coming rising edge will do.
    always @(negedge clk) begin : scoreboard
        beat_t head;
        bit    expValid;
        bit    expInReady;
        if (monOn) begin
            expValid   = (expQ.size() != 0);
            expInReady = (expQ.size() == 0) || ((expQ.size() == 1) && out_ready);
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("in_ready", in_ready, expInReady);
            checkOutput("frame_done", frame_done, expFrameDone);
            checkOutput("overrun_err", overrun_err, expOverrun);
            if (expValid) begin
                head = expQ[0];
                checkOutput("out_data", out_data, head.data);
                checkOutput("out_x", out_x, head.x);
                checkOutput("out_y", out_y, head.y);
                checkOutput("flags", {out_sof, out_eol, out_eof}, {head.sof, head.eol, head.eof});
            end else begin
                checkOutput("flags_idle", {out_sof, out_eol, out_eof}, 3'b000);
            end
            if (rst) begin
                expQ.delete();
                expOverrun   = 1'b0;
                expFrameDone = 1'b0;
            end else begin
                expFrameDone = 1'b0;
                if (expValid && out_ready) begin
                    expFrameDone = expQ[0].eof;
                    void'(expQ.pop_front());
                end
                if (in_valid) begin
                    if (expInReady) pushFrame();
                    else expOverrun = 1'b1;
                end
            end
        end
    end

    // Bound on total run time.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  sofCnt;
        int  eolCnt;
        int  eofCnt;
        bit  doneSeen;

        // Spot beats of the pattern frame: channel c of pixel (x,y) holds
        // (c<<6) | ((y*14+x) & 0x3F).
        vectors[0] = '{0,   32'hC0804000, 0,  0,  1'b1, 1'b0, 1'b0};
        vectors[1] = '{13,  32'hCD8D4D0D, 13, 0,  1'b0, 1'b1, 1'b0};
        vectors[2] = '{14,  32'hCE8E4E0E, 0,  1,  1'b0, 1'b0, 1'b0};
        vectors[3] = '{31,  32'hDF9F5F1F, 3,  2,  1'b0, 1'b0, 1'b0};
        vectors[4] = '{56,  32'hF8B87838, 0,  4,  1'b0, 1'b0, 1'b0};
        vectors[5] = '{64,  32'hC0804000, 8,  4,  1'b0, 1'b0, 1'b0};
        vectors[6] = '{131, 32'hC3834303, 5,  9,  1'b0, 1'b0, 1'b0};
        vectors[7] = '{195, 32'hC3834303, 13, 13, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; feature_map_in = '0;
        sRst = 1'b1; sInValid = 1'b0; sOutReady = 1'b0; sFeature = '0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_out_xy", {out_x, out_y}, 8'h00);
        checkOutput("rst_flags", {out_sof, out_eol, out_eof}, 3'b000);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst_overrun", overrun_err, 1'b0);
        rst = 1'b0;
        sRst = 1'b0;
        monOn = 1'b1;
        tick();

        $display("[TB] pattern frame, no backpressure");
        loadPattern();
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        sofCnt = 0; eolCnt = 0; eofCnt = 0;
        for (int b = 0; b < NPIX; b++) begin
            if (out_sof) sofCnt++;
            if (out_eol) eolCnt++;
            if (out_eof) eofCnt++;
            for (int i = 0; i < NUM_VEC; i++) begin
                if (vectors[i].beatIdx == b) begin
                    checkOutput($sformatf("vec%0d_valid", i), out_valid, 1'b1);
                    checkOutput($sformatf("vec%0d_data", i), out_data, vectors[i].expData);
                    checkOutput($sformatf("vec%0d_x", i), out_x, vectors[i].expX);
                    checkOutput($sformatf("vec%0d_y", i), out_y, vectors[i].expY);
                    checkOutput($sformatf("vec%0d_flags", i), {out_sof, out_eol, out_eof},
                                {vectors[i].expSof, vectors[i].expEol, vectors[i].expEof});
                end
            end
            tick();
        end
        checkOutput("t1_sof_count", sofCnt, 1);
        checkOutput("t1_eol_count", eolCnt, 14);
        checkOutput("t1_eof_count", eofCnt, 1);
        checkOutput("t1_frame_done", frame_done, 1'b1);
        checkOutput("t1_back_idle", out_valid, 1'b0);

        $display("[TB] pattern frame, out_ready toggling");
        loadPattern();
        applyStimulus(1'b1, 1'b0);
        in_valid = 1'b0;
        doneSeen = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            out_ready = ~out_ready;
            tick();
            if (frame_done) begin
                doneSeen = 1'b1;
                break;
            end
        end
        checkOutput("t2_frame_done_seen", doneSeen, 1'b1);
        out_ready = 1'b1;
        tick();

        $display("[TB] back-to-back frames");
        loadPattern();
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (NPIX - 1) tick();
        checkOutput("t3_last_beat_eof", out_eof, 1'b1);
        checkOutput("t3_in_ready", in_ready, 1'b1);
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("t3_no_gap", out_valid, 1'b1);
        checkOutput("t3_sof", out_sof, 1'b1);
        checkOutput("t3_f2_pixel0", out_data,
                    {frameTb[3][0][0], frameTb[2][0][0], frameTb[1][0][0], frameTb[0][0][0]});
        checkOutput("t3_done_pulse", frame_done, 1'b1);
        checkOutput("t3_no_overrun", overrun_err, 1'b0);
        repeat (NPIX) tick();
        checkOutput("t3_f2_done", frame_done, 1'b1);
        checkOutput("t3_idle", out_valid, 1'b0);

        $display("[TB] overrun during stream");
        loadPattern();
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (50) tick();
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("t4_overrun_set", overrun_err, 1'b1);
        checkOutput("t4_beat51_xy", {out_x, out_y}, {4'd9, 4'd3});
        checkOutput("t4_beat51_data", out_data, 32'hF3B37333);
        repeat (NPIX - 51) tick();
        checkOutput("t4_done", frame_done, 1'b1);
        checkOutput("t4_idle", out_valid, 1'b0);
        checkOutput("t4_overrun_sticky", overrun_err, 1'b1);

        $display("[TB] reset mid-stream");
        loadPattern();
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_valid_low", out_valid, 1'b0);
        checkOutput("t5_in_ready", in_ready, 1'b1);
        checkOutput("t5_overrun_clr", overrun_err, 1'b0);
        checkOutput("t5_xy_clr", {out_x, out_y}, 8'h00);
        applyStimulus(1'b1, 1'b1);
        in_valid = 1'b0;
        checkOutput("t5_restart_sof", out_sof, 1'b1);
        checkOutput("t5_restart_data", out_data, 32'hC0804000);
        repeat (NPIX) tick();
        checkOutput("t5_done", frame_done, 1'b1);

        $display("[TB] random traffic");
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                loadRandom();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NPIX + 10) tick();
        checkOutput("t6_drained", out_valid, 1'b0);

        $display("[TB] 4x4x2 instance");
        for (int c = 0; c < SC; c++)
            for (int y = 0; y < SH; y++)
                for (int x = 0; x < SW; x++) begin
                    sFrame[c][y][x] = 8'($urandom_range(0, 255));
                    sFeature[c*FB*SNPIX + (y*SW + x)*FB +: FB] = sFrame[c][y][x];
                end
        checkOutput("s_in_ready", sInReady, 1'b1);
        sInValid  = 1'b1;
        sOutReady = 1'b1;
        tick();
        sInValid = 1'b0;
        for (int b = 0; b < SNPIX; b++) begin
            checkOutput($sformatf("s_valid%0d", b), sOutValid, 1'b1);
            checkOutput($sformatf("s_data%0d", b), sOutData,
                        {sFrame[1][b/SW][b%SW], sFrame[0][b/SW][b%SW]});
            checkOutput($sformatf("s_xy%0d", b), {sOutX, sOutY}, {2'(b % SW), 2'(b / SW)});
            checkOutput($sformatf("s_flags%0d", b), {sOutSof, sOutEol, sOutEof},
                        {b == 0, (b % SW) == SW - 1, b == SNPIX - 1});
            tick();
        end
        checkOutput("s_done", sFrameDone, 1'b1);
        checkOutput("s_idle", sOutValid, 1'b0);
        checkOutput("s_overrun", sOverrun, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pool_feature_serializer.md
Name: pool_feature_serializer

Overview:
- Sits directly downstream of the layer-1 2x2 max-pooling stage and consumes its whole-frame parallel output (14x14x4, 8-bit).
- Captures one frame on the pooling stage's result-valid pulse, then streams it out in raster order, one pixel per beat, with all channels in parallel.
- Output uses a valid/ready handshake so the layer-2 line-buffer or convolution front end can apply backpressure.

Parameters:
- CHANNELS, 4, channels per pixel
- FEATURE_BITWIDTH, 8, bits per channel value
- MAP_WIDTH, 14, pixels per row
- MAP_HEIGHT, 14, rows per frame
- PIX_CNT_W, $clog2(MAP_WIDTH*MAP_HEIGHT), pixel-index width (derived)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle frame-valid pulse from the pooling stage
- in_ready  out  1  serializer can capture a frame this cycle
- feature_map_in  in  CHANNELS*FEATURE_BITWIDTH*MAP_WIDTH*MAP_HEIGHT  frame; channel c, pixel (x,y) at [c*FB*W*H + (y*W+x)*FB +: FB]
- out_valid  out  1  out_* fields hold a valid beat
- out_ready  in  1  downstream accepts the beat
- out_data  out  CHANNELS*FEATURE_BITWIDTH  pixel; channel c at [c*FB +: FB]
- out_x  out  $clog2(MAP_WIDTH)  column of the current beat
- out_y  out  $clog2(MAP_HEIGHT)  row of the current beat
- out_sof  out  1  beat is pixel (0,0)
- out_eol  out  1  beat is x = MAP_WIDTH-1
- out_eof  out  1  beat is the last pixel of the frame
- frame_done  out  1  one-cycle pulse after the final beat handshake
- overrun_err  out  1  sticky flag: frame offered while not ready

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pixel counter=0, out_valid=0, out_data/out_x/out_y=0, flags=0, frame_done=0, overrun_err=0. Capture buffer contents are don't-care. Reset mid-stream abandons the frame, with out_valid low from the next cycle.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, capture feature_map_in, set counter=0, go to STREAM.
  - STREAM: out_valid=1. A handshake (out_valid&&out_ready) advances the counter.
    - Handshake on the last pixel with in_valid=0: go to IDLE.
    - Handshake on the last pixel with in_valid=1: capture the new frame, counter=0, stay in STREAM. This is a back-to-back frame with no bubble.
- in_ready=1 in IDLE, and in STREAM only while the counter is at the last pixel and out_ready=1. It is combinational.
- Latency: in_valid accepted at cycle N gives out_valid=1 with pixel (0,0) at cycle N+1. An unstalled frame takes exactly MAP_WIDTH*MAP_HEIGHT (196) beats.
- Beat contents are registered, selected from the capture buffer by the counter. x and y are kept as separate counters: x wraps at W-1 and increments y; y wraps at H-1.
- Stall: while out_valid&&!out_ready, all out_* fields hold stable. out_valid never drops without a handshake, except on reset.
- Overrun: in_valid=1 while in_ready=0 means the frame is dropped, the current stream is unaffected, and overrun_err is set until rst.
- frame_done pulses in the cycle after the last-pixel handshake, including the back-to-back case.
- Flags are combinational from the counters and qualified by out_valid: out_sof = out_valid && x==0 && y==0; out_eol = out_valid && x==W-1; out_eof = out_valid && x==W-1 && y==H-1.
- No arithmetic on data; values pass through bit-exact.

Decomposition:
- Shared layer-1 package/include holds:
  - constants: CHANNELS, FEATURE_BITWIDTH, POOL_OUT_WIDTH=14, POOL_OUT_HEIGHT=14
  - FSM state encoding (IDLE=0, STREAM=1)
  - a pixel-slice index function shared with the pooling stage, so both use the same frame bit layout
- One natural sub-module, fmap_raster_counter: x/y counters with advance, clear, last and eol outputs. It is reusable by layer-2 stages.

Test Plan:
- Frame with channel c pixel (x,y) = (c<<6)|(y*14+x)&0x3F, out_ready=1 → beats 0..195 on consecutive cycles starting N+1. Beat (x=3,y=2) has out_data = {0xDF,0x9F,0x5F,0x1F}. out_sof only on beat 0, out_eol on 14 beats, out_eof on beat 195, frame_done at N+197.
- Same frame, out_ready toggled 1/0 each cycle → 196 beats in order, fields stable during stalls, out_eof on beat (13,13), no loss or duplication.
- Second in_valid in the cycle of the last-pixel handshake → next cycle shows out_sof with frame-2 pixel (0,0). There is no out_valid gap and overrun_err=0.
- in_valid at beat 50 with out_ready=1 → beats 51..195 still come from frame 1, then IDLE, and overrun_err=1.
- rst=1 at beat 100 → out_valid=0, in_ready=1 the next cycle. A new frame then restarts at (0,0), and overrun_err is cleared.
- Parameter override W=H=4, CHANNELS=2 → 16 beats, out_eol every 4th beat, out_x/out_y wrap correctly.
